// File: rtl/qpu_ift2itcm_pkg.sv
// Shared types and constants for the IFU-to-ITCM fetch bridge.
// The optional holdup buffer is enabled by defining QPU_ITCM_HOLDUP_EN.
package qpu_ift2itcm_pkg;

    localparam int unsigned LINE_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] ITCM_BASE_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD1  = 2'd1,
        ST_HOLD = 2'd2
    } ift_state_e;

    function automatic logic [INSTR_W-1:0] line_half(input logic [LINE_W-1:0] line,
                                                     input logic               sel);
        logic [INSTR_W-1:0] res;
        if (sel) begin
            res = line[63:32];
        end else begin
            res = line[31:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/qpu_ift2itcm_chk.sv
// Protocol checker for the fetch bridge: single-outstanding contract and stall stability.
module qpu_ift2itcm_chk (
    input logic        clk,
    input logic        rst_n,
    input logic        req_valid,
    input logic        req_ready,
    input logic        rsp_valid,
    input logic        rsp_ready,
    input logic [31:0] rsp_instr,
    input logic        rsp_err
);

    a_single_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_valid && req_ready && rsp_valid && !rsp_ready));

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=> ($stable(rsp_instr) && $stable(rsp_err) && rsp_valid));

endmodule

// File: rtl/qpu_ift2itcm_linebuf.sv
// 64-bit line buffer plus holdup tracking (held index, valid bit, hit compare).
// Holdup logic exists only when QPU_ITCM_HOLDUP_EN is defined.
module qpu_ift2itcm_linebuf
    import qpu_ift2itcm_pkg::*;
#(
    parameter int unsigned ITCM_AW = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd1_cyc,
    input  logic [LINE_W-1:0]  itcm_rdata,
    input  logic               sram_rd,
    input  logic [ITCM_AW-1:0] line_idx,
    input  logic               req_accept,
    input  logic               req_seq,
    input  logic               req_err,
    input  logic               wr_snoop,
    output logic [LINE_W-1:0]  line_q,
    output logic               holdup_hit
);

    logic [LINE_W-1:0] line_r;

    // Line buffer: refreshed on every RD1 cycle so stalls and hits see stable data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r <= {LINE_W{1'b0}};
        end else if (rd1_cyc) begin
            line_r <= itcm_rdata;
        end else begin
            line_r <= line_r;
        end
    end

    assign line_q = line_r;

`ifdef QPU_ITCM_HOLDUP_EN
    logic [ITCM_AW-1:0] held_idx_r;
    logic               holdup_vld_r;

    // Held index: line of the most recent SRAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_idx_r <= {ITCM_AW{1'b0}};
        end else if (sram_rd) begin
            held_idx_r <= line_idx;
        end else begin
            held_idx_r <= held_idx_r;
        end
    end

    // Holdup valid: a foreign write or an error fetch invalidates before RD1 can set it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdup_vld_r <= 1'b0;
        end else if (wr_snoop | (req_accept & req_err)) begin
            holdup_vld_r <= 1'b0;
        end else if (rd1_cyc) begin
            holdup_vld_r <= 1'b1;
        end else begin
            holdup_vld_r <= holdup_vld_r;
        end
    end

    // A snoop in the same cycle vetoes the hit so the fresh SRAM contents are read.
    assign holdup_hit = req_seq & holdup_vld_r & (line_idx == held_idx_r)
                      & ~req_err & ~wr_snoop;
`else
    logic unused_holdup_s;

    assign holdup_hit      = 1'b0;
    assign unused_holdup_s = &{1'b0, sram_rd, line_idx, req_accept, req_seq, req_err, wr_snoop};
`endif

endmodule

// File: rtl/qpu_ifu_ift2itcm.sv
// IFU fetch to ITCM bridge: one outstanding fetch, 64-bit line read, 32-bit select.
// Optional sequential-fetch holdup buffer via QPU_ITCM_HOLDUP_EN.
module qpu_ifu_ift2itcm
    import qpu_ift2itcm_pkg::*;
#(
    parameter int unsigned        PC_W      = 32,
    parameter int unsigned        ITCM_AW   = 13,
    parameter logic [PC_W-1:0]    ITCM_BASE = PC_W'(ITCM_BASE_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [PC_W-1:0]    ifu_req_pc,
    input  logic               ifu_req_seq,
    output logic               ifu_rsp_valid,
    input  logic               ifu_rsp_ready,
    output logic [31:0]        ifu_rsp_instr,
    output logic               ifu_rsp_err,
    input  logic               itcm_ready,
    output logic               itcm_cs,
    output logic [ITCM_AW-1:0] itcm_addr,
    input  logic [LINE_W-1:0]  itcm_rdata,
    input  logic               itcm_wr_snoop
);

    ift_state_e         state_r;
    ift_state_e         state_nxt_s;
    logic               accept_s;
    logic               hit_itcm_s;
    logic               err_s;
    logic               holdup_hit_s;
    logic               sram_rd_s;
    logic [ITCM_AW-1:0] line_idx_s;
    logic [LINE_W-1:0]  line_q_s;
    logic               half_sel_r;
    logic               err_r;
    logic [31:0]        rsp_instr_s;
    logic               unused_pc0_s;

    // Request ready follows only the arbiter grant, never the response side.
    assign ifu_req_ready = itcm_ready;
    assign accept_s      = ifu_req_valid & itcm_ready;
    assign hit_itcm_s    = (ifu_req_pc[PC_W-1:ITCM_AW+3] == ITCM_BASE[PC_W-1:ITCM_AW+3]);
    assign err_s         = ~hit_itcm_s | ifu_req_pc[1];
    assign line_idx_s    = ifu_req_pc[ITCM_AW+2:3];
    assign sram_rd_s     = accept_s & ~err_s & ~holdup_hit_s;
    assign unused_pc0_s  = ifu_req_pc[0];

    assign itcm_cs   = sram_rd_s;
    assign itcm_addr = line_idx_s;

    qpu_ift2itcm_linebuf #(
        .ITCM_AW (ITCM_AW)
    ) u_linebuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd1_cyc    (state_r == ST_RD1),
        .itcm_rdata (itcm_rdata),
        .sram_rd    (sram_rd_s),
        .line_idx   (line_idx_s),
        .req_accept (accept_s),
        .req_seq    (ifu_req_seq),
        .req_err    (err_s),
        .wr_snoop   (itcm_wr_snoop),
        .line_q     (line_q_s),
        .holdup_hit (holdup_hit_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: a new accept always wins, then handshake, then RD1 falls into HOLD.
    always_comb begin
        state_nxt_s = state_r;
        if (accept_s) begin
            state_nxt_s = sram_rd_s ? ST_RD1 : ST_HOLD;
        end else if ((state_r != ST_IDLE) && ifu_rsp_ready) begin
            state_nxt_s = ST_IDLE;
        end else if (state_r == ST_RD1) begin
            state_nxt_s = ST_HOLD;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Half select and error flag captured at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_sel_r <= 1'b0;
            err_r      <= 1'b0;
        end else if (accept_s) begin
            half_sel_r <= ifu_req_pc[2];
            err_r      <= err_s;
        end else begin
            half_sel_r <= half_sel_r;
            err_r      <= err_r;
        end
    end

    // Response data: live SRAM data in RD1, buffered line or zero in HOLD.
    always_comb begin
        rsp_instr_s = 32'h0000_0000;
        case (state_r)
            ST_RD1:  rsp_instr_s = line_half(itcm_rdata, half_sel_r);
            ST_HOLD: rsp_instr_s = err_r ? 32'h0000_0000 : line_half(line_q_s, half_sel_r);
            default: rsp_instr_s = 32'h0000_0000;
        endcase
    end

    assign ifu_rsp_valid = (state_r != ST_IDLE);
    assign ifu_rsp_instr = rsp_instr_s;
    assign ifu_rsp_err   = (state_r == ST_HOLD) & err_r;

    qpu_ift2itcm_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (ifu_req_valid),
        .req_ready (ifu_req_ready),
        .rsp_valid (ifu_rsp_valid),
        .rsp_ready (ifu_rsp_ready),
        .rsp_instr (ifu_rsp_instr),
        .rsp_err   (ifu_rsp_err)
    );

endmodule
